// File: rtl/bldc_seq_pkg.sv
// Shared types and constants for the BLDC start sequencer: state codes,
// fault-cause codes and the hall codes that can never occur on a healthy sensor.
package bldc_seq_pkg;

    localparam int REF_W  = 12;
    localparam int HALL_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ALIGN    = 3'd1,
        ST_RAMP     = 3'd2,
        ST_CLOSED   = 3'd3,
        ST_STOPPING = 3'd4,
        ST_FAULT    = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'd0,
        CAUSE_INVALID_HALL = 2'd1,
        CAUSE_STALL        = 2'd2
    } fault_cause_t;

    localparam logic [HALL_W-1:0] HALL_INVALID_LO = 3'b000;
    localparam logic [HALL_W-1:0] HALL_INVALID_HI = 3'b111;

    // All-low or all-high means a disconnected or shorted sensor.
    function automatic logic hall_is_invalid(input logic [HALL_W-1:0] code);
        return (code == HALL_INVALID_LO) || (code == HALL_INVALID_HI);
    endfunction

endpackage

// File: rtl/bldc_hall_edge_detect.sv
// Hall sensor front end: 2-flop synchroniser plus a previous-code register.
// edge/invalid are decoded from flops, so a pin change is acted on by the
// sequencer at the 3rd rising clock after it happens.
module bldc_hall_edge_detect
    import bldc_seq_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [HALL_W-1:0] i_hall_state,
    output logic              o_edge,
    output logic              o_invalid
);

    logic [HALL_W-1:0] sync1;
    logic [HALL_W-1:0] sync2;
    logic [HALL_W-1:0] prev;

    // Synchronise the asynchronous hall pins and remember the last settled code.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= i_hall_state;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // An edge only counts between two valid codes; a glitch through 000/111 is not rotation.
    always_comb begin
        o_invalid = hall_is_invalid(sync2);
        o_edge    = (sync2 != prev) && !hall_is_invalid(sync2) && !hall_is_invalid(prev);
    end

endmodule

// File: rtl/bldc_start_sequencer.sv
// Motor start supervisor: align -> open-loop ramp -> closed-loop handover,
// controlled ramp-down on stop, and a latched fault on invalid hall or stall.
// Commands (i_start, i_stop, i_clear_fault) are single-cycle pulses sampled on
// the rising clock; there is no handshake, a pulse that is not legal in the
// current state is simply dropped.
module bldc_start_sequencer
    import bldc_seq_pkg::*;
#(
    parameter int unsigned       ALIGN_CYCLES     = 1000000,
    parameter int unsigned       RAMP_STEP_CYCLES = 10000,
    parameter int unsigned       RAMP_STEP        = 8,
    parameter logic [REF_W-1:0]  OPEN_LOOP_DUTY   = 12'h200,
    parameter int unsigned       HANDOVER_EDGES   = 12,
    parameter int unsigned       STALL_CYCLES     = 5000000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_clear_fault,
    input  logic [REF_W-1:0]  i_target_ref,
    input  logic [HALL_W-1:0] i_hall_state,
    output logic              o_enable_control,
    output logic              o_bypass,
    output logic [REF_W-1:0]  o_reference,
    output logic [2:0]        o_state,
    output logic              o_fault,
    output logic [1:0]        o_fault_cause,
    output logic [7:0]        o_edge_count
);

    localparam int unsigned PHASE_MAX = (ALIGN_CYCLES > RAMP_STEP_CYCLES) ? ALIGN_CYCLES : RAMP_STEP_CYCLES;
    localparam int PHASE_W = $clog2(PHASE_MAX + 1);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam int HO_W    = $clog2(HANDOVER_EDGES + 1);
    localparam logic [REF_W:0] STEP13 = (REF_W+1)'(RAMP_STEP);

    seq_state_t         state;
    logic [PHASE_W-1:0] phase_cnt;   // align duration, then ramp step spacing
    logic [STALL_W-1:0] stall_cnt;
    logic [HO_W-1:0]    ho_cnt;      // valid edges seen in RAMP
    logic               hall_edge;
    logic               hall_invalid;

    logic               run_state;
    logic               fault_req;
    logic [1:0]         fault_cause_req;
    logic               stop_req;
    logic               start_accept;
    logic               align_done;
    logic               step_due;
    logic [REF_W:0]     ref_sum;
    logic [REF_W:0]     ref_diff;
    logic [REF_W-1:0]   ref_up;
    logic [REF_W-1:0]   ref_dn;

    bldc_hall_edge_detect u_hall (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_hall_state (i_hall_state),
        .o_edge       (hall_edge),
        .o_invalid    (hall_invalid)
    );

    assign o_state = state;

    // Request decode and 13-bit clamped reference arithmetic for the ramps.
    always_comb begin
        run_state       = (state == ST_ALIGN) || (state == ST_RAMP) || (state == ST_CLOSED);
        fault_req       = run_state && (hall_invalid ||
                          ((state != ST_ALIGN) && !hall_edge && (stall_cnt == STALL_W'(STALL_CYCLES - 1))));
        fault_cause_req = hall_invalid ? CAUSE_INVALID_HALL : CAUSE_STALL;
        stop_req        = run_state && i_stop;
        // A stop in the same cycle as a start keeps the motor idle.
        start_accept    = (state == ST_IDLE) && i_start && !i_stop;
        align_done      = (phase_cnt == PHASE_W'(ALIGN_CYCLES - 1));
        step_due        = (phase_cnt == PHASE_W'(RAMP_STEP_CYCLES - 1));

        ref_sum  = {1'b0, o_reference} + STEP13;
        ref_diff = {1'b0, o_reference} - STEP13;
        // Ramp up never steps down: a target below the current ref just holds it.
        if (o_reference >= i_target_ref)
            ref_up = o_reference;
        else if (ref_sum > {1'b0, i_target_ref})
            ref_up = i_target_ref;
        else
            ref_up = ref_sum[REF_W-1:0];
        ref_dn = ref_diff[REF_W] ? '0 : ref_diff[REF_W-1:0];
    end

    // Saturating hall-edge count since the last accepted start.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_edge_count <= '0;
        else if (start_accept)
            o_edge_count <= '0;
        else if ((state != ST_IDLE) && hall_edge && (o_edge_count != 8'hFF))
            o_edge_count <= o_edge_count + 8'd1;
    end

    // Sequencer FSM with registered controller outputs; fault beats stop beats progression.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state            <= ST_IDLE;
            o_enable_control <= 1'b0;
            o_bypass         <= 1'b1;
            o_reference      <= '0;
            o_fault          <= 1'b0;
            o_fault_cause    <= CAUSE_NONE;
            phase_cnt        <= '0;
            stall_cnt        <= '0;
            ho_cnt           <= '0;
        end else if (fault_req) begin
            state            <= ST_FAULT;
            o_enable_control <= 1'b0;
            o_bypass         <= 1'b1;
            o_reference      <= '0;
            o_fault          <= 1'b1;
            o_fault_cause    <= fault_cause_req;
        end else if (stop_req) begin
            // Ramp-down starts from whatever reference is being applied now.
            state     <= ST_STOPPING;
            o_bypass  <= 1'b1;
            phase_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        state            <= ST_ALIGN;
                        o_enable_control <= 1'b1;
                        o_bypass         <= 1'b1;
                        o_reference      <= OPEN_LOOP_DUTY;
                        phase_cnt        <= '0;
                    end
                end
                ST_ALIGN: begin
                    if (align_done) begin
                        state     <= ST_RAMP;
                        phase_cnt <= '0;
                        stall_cnt <= '0;
                        ho_cnt    <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_W'(1);
                    end
                end
                ST_RAMP: begin
                    if (hall_edge && (ho_cnt == HO_W'(HANDOVER_EDGES - 1))) begin
                        state       <= ST_CLOSED;
                        o_bypass    <= 1'b0;
                        o_reference <= i_target_ref;
                        stall_cnt   <= '0;
                    end else begin
                        if (hall_edge) begin
                            ho_cnt    <= ho_cnt + HO_W'(1);
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                        if (step_due) begin
                            phase_cnt   <= '0;
                            o_reference <= ref_up;
                        end else begin
                            phase_cnt <= phase_cnt + PHASE_W'(1);
                        end
                    end
                end
                ST_CLOSED: begin
                    o_reference <= i_target_ref;
                    stall_cnt   <= hall_edge ? '0 : stall_cnt + STALL_W'(1);
                end
                ST_STOPPING: begin
                    if (o_reference == '0) begin
                        state            <= ST_IDLE;
                        o_enable_control <= 1'b0;
                        o_bypass         <= 1'b1;
                    end else if (step_due) begin
                        phase_cnt   <= '0;
                        o_reference <= ref_dn;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (i_clear_fault) begin
                        state         <= ST_IDLE;
                        o_fault       <= 1'b0;
                        o_fault_cause <= CAUSE_NONE;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    o_enable_control <= 1'b0;
                    o_bypass         <= 1'b1;
                    o_reference      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bldc_start_sequencer.sv
// Directed bench for the BLDC start sequencer with shortened timing parameters.
`timescale 1ns/1ps
module tb_bldc_start_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_clear_fault = 1'b0;
    logic [11:0] i_target_ref = 12'd96;
    logic [2:0]  i_hall_state = 3'd1;
    logic        o_enable_control;
    logic        o_bypass;
    logic [11:0] o_reference;
    logic [2:0]  o_state;
    logic        o_fault;
    logic [1:0]  o_fault_cause;
    logic [7:0]  o_edge_count;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_q[$];
    logic [2:0]  hall_seq [6] = '{3'd5, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1};

    bldc_start_sequencer #(
        .ALIGN_CYCLES     (10),
        .RAMP_STEP_CYCLES (4),
        .RAMP_STEP        (16),
        .OPEN_LOOP_DUTY   (12'd32),
        .HANDOVER_EDGES   (6),
        .STALL_CYCLES     (50)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .i_stop           (i_stop),
        .i_clear_fault    (i_clear_fault),
        .i_target_ref     (i_target_ref),
        .i_hall_state     (i_hall_state),
        .o_enable_control (o_enable_control),
        .o_bypass         (o_bypass),
        .o_reference      (o_reference),
        .o_state          (o_state),
        .o_fault          (o_fault),
        .o_fault_cause    (o_fault_cause),
        .o_edge_count     (o_edge_count)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    // Driver tasks: inputs change 1 ns after the rising edge, outputs sampled there too.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear_fault = 1'b1;
        tick();
        i_clear_fault = 1'b0;
    endtask

    // Start from IDLE with hall=1 settled; returns on the cycle CLOSED is entered.
    task automatic run_to_closed();
        pulse_start();
        repeat (10) tick();
        for (int k = 0; k < 6; k++) begin
            repeat (8) tick();
            i_hall_state = hall_seq[k];
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        checks++; if (o_enable_control !== 1'b0) begin failures++; $display("FAIL reset_enable got=%0b exp=0", o_enable_control); end
        checks++; if (o_bypass !== 1'b1) begin failures++; $display("FAIL reset_bypass got=%0b exp=1", o_bypass); end
        checks++; if (o_reference !== 12'd0) begin failures++; $display("FAIL reset_ref got=%0d exp=0", o_reference); end
        checks++; if (o_fault !== 1'b0 || o_fault_cause !== 2'd0) begin failures++; $display("FAIL reset_fault got=%0b/%0d exp=0/0", o_fault, o_fault_cause); end
        checks++; if (o_edge_count !== 8'd0) begin failures++; $display("FAIL reset_edges got=%0d exp=0", o_edge_count); end
        i_reset = 1'b0;
        repeat (3) tick();
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL post_reset_state got=%0d exp=0", o_state); end
    endtask

    task automatic test_start_ramp_closed();
        logic [11:0] e;
        pulse_start();
        checks++; if (o_state !== 3'd1 || o_enable_control !== 1'b1 || o_bypass !== 1'b1) begin failures++; $display("FAIL align_entry got=st%0d en%0b byp%0b exp=st1 en1 byp1", o_state, o_enable_control, o_bypass); end
        checks++; if (o_reference !== 12'd32) begin failures++; $display("FAIL align_ref got=%0d exp=32", o_reference); end
        repeat (9) tick();
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL align_last_cycle got=%0d exp=1", o_state); end
        tick();
        checks++; if (o_state !== 3'd2 || o_reference !== 12'd32) begin failures++; $display("FAIL ramp_entry got=st%0d ref%0d exp=st2 ref32", o_state, o_reference); end
        exp_q = '{12'd48, 12'd64, 12'd80, 12'd96, 12'd96};
        for (int n = 1; n <= 51; n++) begin
            tick();
            if (n % 4 == 0 && n <= 20) begin
                e = exp_q.pop_front();
                checks++; if (o_reference !== e) begin failures++; $display("FAIL ramp_ref cycle=%0d got=%0d exp=%0d", n, o_reference, e); end
            end
            if (n == 50) begin
                checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL pre_handover got=%0d exp=2", o_state); end
            end
            if (n == 51) begin
                checks++; if (o_state !== 3'd3 || o_bypass !== 1'b0) begin failures++; $display("FAIL handover got=st%0d byp%0b exp=st3 byp0", o_state, o_bypass); end
                checks++; if (o_edge_count !== 8'd6) begin failures++; $display("FAIL handover_edges got=%0d exp=6", o_edge_count); end
            end
            if (n % 8 == 0 && n <= 48) i_hall_state = hall_seq[n / 8 - 1];
        end
        i_target_ref = 12'd200;
        checks++; if (o_reference !== 12'd96) begin failures++; $display("FAIL closed_latency got=%0d exp=96", o_reference); end
        tick();
        checks++; if (o_reference !== 12'd200) begin failures++; $display("FAIL closed_track got=%0d exp=200", o_reference); end
        i_target_ref = 12'd96;
        tick();
        checks++; if (o_reference !== 12'd96 || o_state !== 3'd3) begin failures++; $display("FAIL closed_back got=st%0d ref%0d exp=st3 ref96", o_state, o_reference); end
    endtask

    task automatic test_stop();
        logic [11:0] e;
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        checks++; if (o_state !== 3'd4 || o_bypass !== 1'b1 || o_reference !== 12'd96) begin failures++; $display("FAIL stop_entry got=st%0d byp%0b ref%0d exp=st4 byp1 ref96", o_state, o_bypass, o_reference); end
        exp_q = '{12'd80, 12'd64, 12'd48, 12'd32, 12'd16, 12'd0};
        while (exp_q.size() > 0) begin
            repeat (4) tick();
            e = exp_q.pop_front();
            checks++; if (o_reference !== e || o_state !== 3'd4) begin failures++; $display("FAIL stop_ramp got=st%0d ref%0d exp=st4 ref%0d", o_state, o_reference, e); end
        end
        tick();
        checks++; if (o_state !== 3'd0 || o_enable_control !== 1'b0 || o_reference !== 12'd0) begin failures++; $display("FAIL stop_idle got=st%0d en%0b ref%0d exp=st0 en0 ref0", o_state, o_enable_control, o_reference); end
    endtask

    task automatic test_stall_fault();
        pulse_start();
        repeat (10) tick();
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL stall_ramp_entry got=%0d exp=2", o_state); end
        for (int n = 1; n <= 50; n++) begin
            tick();
            if (n == 49) begin
                checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL stall_early got=%0d exp=2", o_state); end
            end
        end
        checks++; if (o_state !== 3'd5 || o_fault !== 1'b1 || o_fault_cause !== 2'd2) begin failures++; $display("FAIL stall_fault got=st%0d f%0b c%0d exp=st5 f1 c2", o_state, o_fault, o_fault_cause); end
        checks++; if (o_enable_control !== 1'b0 || o_reference !== 12'd0 || o_bypass !== 1'b1) begin failures++; $display("FAIL stall_outputs got=en%0b ref%0d byp%0b exp=en0 ref0 byp1", o_enable_control, o_reference, o_bypass); end
        pulse_start();
        checks++; if (o_state !== 3'd5) begin failures++; $display("FAIL fault_ignores_start got=%0d exp=5", o_state); end
        pulse_clear();
        checks++; if (o_state !== 3'd0 || o_fault !== 1'b0 || o_fault_cause !== 2'd0) begin failures++; $display("FAIL clear_fault got=st%0d f%0b c%0d exp=st0 f0 c0", o_state, o_fault, o_fault_cause); end
    endtask

    task automatic test_invalid_hall();
        i_hall_state = 3'b000;
        repeat (5) tick();
        checks++; if (o_state !== 3'd0 || o_fault !== 1'b0) begin failures++; $display("FAIL idle_invalid_ignored got=st%0d f%0b exp=st0 f0", o_state, o_fault); end
        i_hall_state = 3'd1;
        repeat (3) tick();
        run_to_closed();
        checks++; if (o_state !== 3'd3) begin failures++; $display("FAIL invalid_setup got=%0d exp=3", o_state); end
        i_hall_state = 3'b111;
        repeat (2) tick();
        checks++; if (o_state !== 3'd3) begin failures++; $display("FAIL invalid_early got=%0d exp=3", o_state); end
        tick();
        checks++; if (o_state !== 3'd5 || o_fault_cause !== 2'd1) begin failures++; $display("FAIL invalid_fault got=st%0d c%0d exp=st5 c1", o_state, o_fault_cause); end
        i_hall_state = 3'd1;
        pulse_clear();
        checks++; if (o_state !== 3'd0 || o_fault_cause !== 2'd0) begin failures++; $display("FAIL invalid_clear got=st%0d c%0d exp=st0 c0", o_state, o_fault_cause); end
        repeat (3) tick();
    endtask

    task automatic test_priority();
        run_to_closed();
        repeat (49) tick();
        checks++; if (o_state !== 3'd3) begin failures++; $display("FAIL prio_closed got=%0d exp=3", o_state); end
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        checks++; if (o_state !== 3'd5 || o_fault_cause !== 2'd2) begin failures++; $display("FAIL fault_beats_stop got=st%0d c%0d exp=st5 c2", o_state, o_fault_cause); end
        pulse_clear();
        i_start = 1'b1;
        i_stop = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop = 1'b0;
        checks++; if (o_state !== 3'd0 || o_enable_control !== 1'b0) begin failures++; $display("FAIL start_stop_idle got=st%0d en%0b exp=st0 en0", o_state, o_enable_control); end
        tick();
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL start_stop_idle2 got=%0d exp=0", o_state); end
    endtask

    task automatic test_reset_mid_ramp();
        pulse_start();
        repeat (10) tick();
        repeat (5) tick();
        i_hall_state = 3'd5;
        repeat (8) tick();
        i_hall_state = 3'd4;
        repeat (8) tick();
        checks++; if (o_state !== 3'd2 || o_edge_count !== 8'd2 || o_reference !== 12'd96) begin failures++; $display("FAIL mid_ramp got=st%0d e%0d ref%0d exp=st2 e2 ref96", o_state, o_edge_count, o_reference); end
        #2 i_reset = 1'b1;
        #1;
        checks++; if (o_state !== 3'd0 || o_enable_control !== 1'b0 || o_bypass !== 1'b1 || o_reference !== 12'd0) begin failures++; $display("FAIL async_reset got=st%0d en%0b byp%0b ref%0d exp=st0 en0 byp1 ref0", o_state, o_enable_control, o_bypass, o_reference); end
        checks++; if (o_edge_count !== 8'd0) begin failures++; $display("FAIL async_reset_edges got=%0d exp=0", o_edge_count); end
        repeat (2) tick();
        i_reset = 1'b0;
        repeat (3) tick();
        pulse_start();
        checks++; if (o_state !== 3'd1 || o_reference !== 12'd32 || o_edge_count !== 8'd0) begin failures++; $display("FAIL restart_align got=st%0d ref%0d e%0d exp=st1 ref32 e0", o_state, o_reference, o_edge_count); end
        repeat (9) tick();
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL restart_align_len got=%0d exp=1", o_state); end
        tick();
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL restart_ramp got=%0d exp=2", o_state); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_start_ramp_closed();
        test_stop();
        test_stall_fault();
        test_invalid_hall();
        test_priority();
        test_reset_mid_ramp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bldc_start_sequencer.md
Name: bldc_start_sequencer

Overview:
- Supervises the BLDC controller datapath through a motor start: rotor alignment, open-loop duty ramp, handover to closed-loop PI control, controlled stop, and fault latch.
- Drives the controller's enable_control, bypass and reference inputs.
- Watches the raw hall inputs for edges, invalid codes and stall.
- Sits between the AXI register block (start/stop/target commands) and the controller instance.

Parameters:
- ALIGN_CYCLES, 1000000, clock cycles spent in alignment at fixed duty.
- RAMP_STEP_CYCLES, 10000, clock cycles between reference steps during ramp up and ramp down.
- RAMP_STEP, 8, reference increment/decrement per step (12-bit units).
- OPEN_LOOP_DUTY, 12'h200, reference applied during alignment and at ramp start.
- HANDOVER_EDGES, 12, valid hall edges counted in RAMP before switching to closed loop.
- STALL_CYCLES, 5000000, maximum cycles without a hall edge in RAMP/CLOSED before fault.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  single-cycle start command
- i_stop  in  1  single-cycle stop command
- i_clear_fault  in  1  single-cycle fault clear
- i_target_ref  in  12  closed-loop reference / ramp ceiling
- i_hall_state  in  3  raw hall sensor code (asynchronous)
- o_enable_control  out  1  to controller enable
- o_bypass  out  1  to controller bypass (1 = open loop)
- o_reference  out  12  to controller reference
- o_state  out  3  current state code
- o_fault  out  1  fault latched
- o_fault_cause  out  2  0 none, 1 invalid hall, 2 stall
- o_edge_count  out  8  saturating hall-edge count since the last start

Behaviour:
- Reset (async assert, sync release): state IDLE, o_enable_control=0, o_bypass=1, o_reference=0, o_fault=0, o_fault_cause=0, o_edge_count=0, all counters 0.
- All outputs are registered.

Hall front end:
- 2-flop synchroniser, then a previous-code register.
- edge = synchronised code differs from previous and both are valid.
- invalid = synchronised code is 3'b000 or 3'b111.
- An input change is reflected in edge/invalid on the 3rd rising clock after the change.

States (o_state code):
- IDLE(0)
  - Outputs: enable=0, bypass=1, ref=0.
  - i_start → ALIGN; clear o_edge_count.
- ALIGN(1)
  - Outputs: enable=1, bypass=1, ref=OPEN_LOOP_DUTY.
  - After ALIGN_CYCLES cycles in state → RAMP; clear the stall timer.
- RAMP(2)
  - Outputs: enable=1, bypass=1.
  - Every RAMP_STEP_CYCLES: ref += RAMP_STEP, saturating at i_target_ref. If i_target_ref < current ref, ref is held (never steps down).
  - On the edge that brings the RAMP edge count to HANDOVER_EDGES → CLOSED.
- CLOSED(3)
  - Outputs: enable=1, bypass=0, ref=i_target_ref registered every cycle (1-cycle latency).
- STOPPING(4)
  - Outputs: enable=1, bypass=1.
  - Every RAMP_STEP_CYCLES: ref -= RAMP_STEP, floored at 0.
  - Cycle after ref reaches 0 → IDLE.
- FAULT(5)
  - Outputs: enable=0, bypass=1, ref=0, o_fault=1.
  - i_clear_fault → IDLE; clears o_fault and o_fault_cause.

Stall timer:
- Runs only in RAMP and CLOSED.
- Cleared on each edge and on state entry.
- Reaching STALL_CYCLES → FAULT, cause=2.

Invalid hall:
- Any invalid sample in ALIGN, RAMP or CLOSED → FAULT, cause=1.
- Ignored in IDLE, STOPPING and FAULT.

Priority on the same cycle: fault > i_stop > i_start/normal progression.
- i_stop in ALIGN, RAMP or CLOSED → STOPPING; the ramp-down starts from the current ref.
- i_stop in IDLE, STOPPING or FAULT is ignored.
- i_start outside IDLE is ignored.
- i_clear_fault outside FAULT is ignored.

Counters and arithmetic:
- o_edge_count increments on every edge in any state except IDLE and saturates at 255.
- Ramp step/stall/align counters use unsigned arithmetic, wide enough for the parameter values, and do not wrap.
- Reference arithmetic is done 13-bit and then clamped, with no wrap.

Reset mid-operation: all outputs return immediately to the reset values above (asynchronously).

Decomposition:
- Package bldc_seq_pkg:
  - state enum and its 3-bit codes;
  - fault-cause codes;
  - invalid hall codes 3'b000 and 3'b111;
  - REF_W=12, HALL_W=3.
- Sub-module bldc_hall_edge_detect: synchroniser, previous-code register, edge and invalid outputs.
- The FSM, counters and reference ramp stay in the top module.

Test Plan:
Common test parameters: ALIGN_CYCLES=10, RAMP_STEP_CYCLES=4, RAMP_STEP=16, OPEN_LOOP_DUTY=32, HANDOVER_EDGES=6, STALL_CYCLES=50, i_target_ref=96.
- Reset, then i_start; valid hall sequence 1,5,4,6,2,3 advanced every 8 cycles → ALIGN with ref=32 for 10 cycles; RAMP with ref 48, 64, 80, 96 (holding at 96); CLOSED on the 6th edge with bypass=0 and ref tracking i_target_ref (change to 200 → ref=200 one cycle later).
- In CLOSED assert i_stop with ref=96 → STOPPING, bypass=1, ref steps 80, 64, …, 0 every 4 cycles, then IDLE with enable=0.
- In RAMP hold the hall code constant for 50 cycles → FAULT, o_fault_cause=2, enable=0, ref=0. i_start is ignored; i_clear_fault → IDLE, o_fault=0.
- In CLOSED drive hall 3'b111 → FAULT with cause=1, 3 cycles after the input change. Also drive 3'b000 in IDLE → no fault.
- Same-cycle i_stop and stall expiry in CLOSED → FAULT (fault wins). Same-cycle i_start and i_stop in IDLE → remains IDLE.
- Assert i_reset mid-RAMP → outputs immediately enable=0, bypass=1, ref=0, state=0. Release, then i_start → a fresh ALIGN of 10 cycles, with o_edge_count restarting from 0.
